// File: rtl/conv_pkg.sv
// Types and helpers shared by the convolutional-code PISO and SIPO converters.
package conv_pkg;

  typedef enum logic {PISO_IDLE, PISO_SHIFT} piso_state_e;

  // Symbol counter width: max(1, $clog2(n)).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_sym_cnt.sv
// Modulo-NUM_SYM symbol counter. Clear and load both restart at symbol 0, and inc wraps after the last symbol.
module conv_sym_cnt
  import conv_pkg::*;
#(
  parameter int NUM_SYM = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_inc,
  output logic o_is_last
);

  localparam int W = cnt_width(NUM_SYM);
  localparam logic [W-1:0] LAST = W'(NUM_SYM - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign o_is_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || i_load) begin
      cnt_d = '0;
    end else if (i_inc) begin
      cnt_d = o_is_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/conv_piso.sv
// Parallel-in/serial-out converter: one SIZE_IN word out as MSB-first SIZE_OUT symbols, with valid/ready on both sides.
// Optional: define CONV_PISO_LAST_EN to add o_last, which marks the final symbol of each word.
module conv_piso
  import conv_pkg::*;
#(
  parameter int SIZE_IN  = 16,
  parameter int SIZE_OUT = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic [SIZE_IN-1:0]  i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [SIZE_OUT-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
`ifdef CONV_PISO_LAST_EN
  output logic                o_last,
`endif
  output logic                o_busy
);

  // state      | meaning
  // PISO_IDLE  | no word held; ready for a new word
  // PISO_SHIFT | presenting symbols of the held word, MSB first

  localparam int NUM_SYM = SIZE_IN / SIZE_OUT;

  if (SIZE_IN % SIZE_OUT != 0) begin : g_size_chk
    $error("conv_piso: SIZE_IN must be a multiple of SIZE_OUT");
  end

  piso_state_e        state_q, state_d;
  logic [SIZE_IN-1:0] shift_q, shift_d;
  logic               cnt_clear, cnt_load, cnt_inc, is_last;

  conv_sym_cnt #(.NUM_SYM(NUM_SYM)) u_sym_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (cnt_clear),
    .i_load   (cnt_load),
    .i_inc    (cnt_inc),
    .o_is_last(is_last)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    o_valid   = (state_q == PISO_SHIFT);
    o_busy    = (state_q == PISO_SHIFT);
    o_data    = shift_q[SIZE_IN-1 -: SIZE_OUT];
    // Ready on the last symbol's transfer lets words stream without a bubble.
    o_ready   = !i_clear && ((state_q == PISO_IDLE) ||
                             ((state_q == PISO_SHIFT) && is_last && i_ready));

    if (i_clear) begin
      state_d   = PISO_IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        PISO_IDLE: begin
          if (i_valid) begin
            shift_d  = i_data;
            cnt_load = 1'b1;
            state_d  = PISO_SHIFT;
          end
        end
        PISO_SHIFT: begin
          if (i_ready) begin
            if (!is_last) begin
              shift_d = shift_q << SIZE_OUT;
              cnt_inc = 1'b1;
            end else if (i_valid) begin
              shift_d  = i_data;
              cnt_load = 1'b1;
            end else begin
              state_d   = PISO_IDLE;
              cnt_clear = 1'b1;
            end
          end
        end
        default: begin
          state_d   = PISO_IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= PISO_IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

`ifdef CONV_PISO_LAST_EN
  assign o_last = o_valid && is_last;
`endif

endmodule

// File: tb/tb_conv_piso.sv
// Self-checking bench for conv_piso: queue-based symbol model, directed plus randomized streams.
module tb_conv_piso;

  localparam int SI = 16;
  localparam int SO = 2;
  localparam int NS = SI / SO;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_clear, a_valid, a_iready;
  logic [SI-1:0] a_idata;
  logic          a_oready, a_ovalid, a_busy;
  logic [SO-1:0] a_odata;
`ifdef CONV_PISO_LAST_EN
  logic          a_last;
  logic          b_last;
`endif

  logic       b_clear, b_valid, b_iready;
  logic [1:0] b_idata;
  logic       b_oready, b_ovalid, b_busy;
  logic [1:0] b_odata;

  conv_piso #(.SIZE_IN(SI), .SIZE_OUT(SO)) dut_a (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_clear(a_clear),
    .i_data (a_idata),
    .i_valid(a_valid),
    .o_ready(a_oready),
    .o_data (a_odata),
    .o_valid(a_ovalid),
    .i_ready(a_iready),
`ifdef CONV_PISO_LAST_EN
    .o_last (a_last),
`endif
    .o_busy (a_busy)
  );

  conv_piso #(.SIZE_IN(2), .SIZE_OUT(2)) dut_b (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_clear(b_clear),
    .i_data (b_idata),
    .i_valid(b_valid),
    .o_ready(b_oready),
    .o_data (b_odata),
    .o_valid(b_ovalid),
    .i_ready(b_iready),
`ifdef CONV_PISO_LAST_EN
    .o_last (b_last),
`endif
    .o_busy (b_busy)
  );

  int tests = 0;
  int fails = 0;
  int q[$];          // pending symbols of the word held by the model
  int obs[$];        // symbols seen transferred by the bench
  int accepted = 0;

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    tests++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic bit model_ready();
    return !a_clear && (q.size() == 0 || (q.size() == 1 && a_iready));
  endfunction

  task automatic check_outputs();
    chk("o_valid", 32'(a_ovalid), 32'(q.size() != 0));
    chk("o_busy", 32'(a_busy), 32'(q.size() != 0));
    chk("o_ready", 32'(a_oready), 32'(model_ready()));
    if (q.size() != 0) chk("o_data", 32'(a_odata), 32'(q[0]));
`ifdef CONV_PISO_LAST_EN
    chk("o_last", 32'(a_last), 32'(q.size() == 1));
`endif
  endtask

  task automatic model_step(input bit rdy);
    if (a_clear) begin
      q.delete();
    end else begin
      if (q.size() != 0 && a_iready) q.pop_front();
      if (a_valid && rdy) begin
        for (int n = 0; n < NS; n++)
          q.push_back(int'((a_idata >> (SI - (n + 1) * SO)) & ((1 << SO) - 1)));
        accepted++;
      end
    end
  endtask

  task automatic cycle();
    bit rdy;
    @(negedge clk);
    check_outputs();
    if (a_ovalid && a_iready) obs.push_back(int'(a_odata));
    rdy = model_ready();
    @(posedge clk);
    model_step(rdy);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    a_valid = 1'b0;
    while (q.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", q.size());
    end
    cycle();
  endtask

  task automatic check_seq(input string tag, input int exp_seq[8]);
    chk({tag, "_len"}, 32'(obs.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs.size(); i++)
      chk(tag, 32'(obs[i]), 32'(exp_seq[i]));
  endtask

  int seq_b4e1[8] = '{2, 3, 1, 0, 3, 2, 0, 1};
  int seq_1234[8] = '{0, 1, 0, 2, 0, 3, 1, 0};

  initial begin
    rst_n = 1'b0;
    a_clear = 1'b0; a_valid = 1'b0; a_iready = 1'b0; a_idata = '0;
    b_clear = 1'b0; b_valid = 1'b0; b_iready = 1'b0; b_idata = '0;
    #12;
    chk("rst_valid", 32'(a_ovalid), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_data", 32'(a_odata), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(a_oready), 1);

    // Single word, no backpressure.
    a_iready = 1'b1;
    a_valid = 1'b1; a_idata = 16'hB4E1;
    cycle();
    a_valid = 1'b0;
    obs.delete();
    drain();
    check_seq("b4e1_seq", seq_b4e1);

    // Two words with i_valid held high: must stream without a gap.
    obs.delete();
    accepted = 0;
    a_valid = 1'b1; a_idata = 16'hFFFF;
    for (int n = 0; n < 40 && accepted < 2; n++) begin
      cycle();
      if (accepted == 1) a_idata = 16'h0000;
    end
    drain();
    chk("stream_len", 32'(obs.size()), 16);
    for (int i = 0; i < 16 && i < obs.size(); i++)
      chk("stream_sym", 32'(obs[i]), (i < 8) ? 32'd3 : 32'd0);

    // Random backpressure on a known word.
    obs.delete();
    a_valid = 1'b1; a_idata = 16'hB4E1; a_iready = 1'b1;
    cycle();
    a_valid = 1'b0;
    for (int n = 0; n < 100 && q.size() != 0; n++) begin
      a_iready = 1'($urandom_range(0, 1));
      cycle();
    end
    a_iready = 1'b1;
    drain();
    check_seq("bp_seq", seq_b4e1);

    // Clear at symbol 3 with a competing valid word.
    a_valid = 1'b1; a_idata = 16'hB4E1;
    cycle();
    a_valid = 1'b0;
    cycle(); cycle(); cycle();
    a_clear = 1'b1; a_valid = 1'b1; a_idata = 16'h1234;
    cycle();
    a_clear = 1'b0; a_valid = 1'b0;
    #1;
    chk("clear_valid", 32'(a_ovalid), 0);
    obs.delete();
    a_valid = 1'b1;
    cycle();
    a_valid = 1'b0;
    drain();
    check_seq("after_clear_seq", seq_1234);

    // Asynchronous reset mid-word.
    a_valid = 1'b1; a_idata = 16'hB4E1;
    cycle();
    a_valid = 1'b0;
    cycle(); cycle();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_ovalid), 0);
    chk("arst_busy", 32'(a_busy), 0);
    chk("arst_data", 32'(a_odata), 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("arst_ready", 32'(a_oready), 1);
    cycle();

    // Randomized streaming with backpressure and occasional clears.
    for (int n = 0; n < 400; n++) begin
      a_valid  = 1'($urandom_range(0, 3) != 0);
      a_idata  = 16'($urandom);
      a_iready = 1'($urandom_range(0, 3) != 0);
      a_clear  = ($urandom_range(0, 31) == 0);
      cycle();
    end
    a_clear = 1'b0; a_iready = 1'b1;
    drain();

    // NUM_SYM == 1 instance: back-to-back single-symbol words.
    b_iready = 1'b1; b_valid = 1'b1; b_idata = 2'b10;
    @(negedge clk);
    chk("b_ready0", 32'(b_oready), 1);
    chk("b_valid0", 32'(b_ovalid), 0);
    @(posedge clk); #1;
    b_idata = 2'b01;
    @(negedge clk);
    chk("b_valid1", 32'(b_ovalid), 1);
    chk("b_data1", 32'(b_odata), 2);
    chk("b_ready1", 32'(b_oready), 1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    chk("b_valid2", 32'(b_ovalid), 1);
    chk("b_data2", 32'(b_odata), 1);
    chk("b_ready2", 32'(b_oready), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_valid3", 32'(b_ovalid), 0);
    chk("b_busy3", 32'(b_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_piso.md
# conv_piso

Parallel-in/serial-out converter for the Viterbi decoder datapath: accepts one SIZE_IN-bit word of convolutional-code bits and emits it as SIZE_IN/SIZE_OUT symbols of SIZE_OUT bits, one symbol per accepted transfer. It is the transmit-side counterpart of the receive-side SIPO: encoder or test-source words go in, and branch-metric-sized symbols come out to the channel model or decoder input. Both sides use valid/ready handshakes, and words stream back-to-back with no bubble cycles.

## Interface
- SIZE_IN, 16, parallel word width in bits; must be an integer multiple of SIZE_OUT.
- SIZE_OUT, 2, symbol width in bits (code rate 1/2 gives 2).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_clear  in  1  synchronous abort: drops the word in flight and returns to IDLE.
- i_data  in  SIZE_IN  parallel word.
- i_valid  in  1  i_data valid.
- o_ready  out  1  block can accept i_data this cycle.
- o_data  out  SIZE_OUT  current symbol.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data this cycle.
- o_busy  out  1  a word is being serialized.

## Operation
- NUM_SYM = SIZE_IN/SIZE_OUT. The counter width is max(1, $clog2(NUM_SYM)).
- Symbol order is MSB-first: symbol n = i_data[SIZE_IN-1-n*SIZE_OUT -: SIZE_OUT].
- FSM states are IDLE and SHIFT.
- IDLE:
  - o_valid=0, o_busy=0, o_ready=!i_clear.
  - When i_valid&&o_ready: load shift_reg<=i_data, cnt<=0, go to SHIFT.
- SHIFT:
  - o_valid=1, o_busy=1, o_data=shift_reg[SIZE_IN-1 -: SIZE_OUT].
  - When i_ready and cnt<NUM_SYM-1: shift_reg<<=SIZE_OUT (zero fill), cnt++.
  - When i_ready and cnt==NUM_SYM-1: if i_valid, reload from i_data with cnt<=0 and stay in SHIFT; otherwise go to IDLE.
  - When !i_ready: hold everything. o_data must stay stable while o_valid&&!i_ready.
- o_ready = !i_clear && (IDLE || (SHIFT && cnt==NUM_SYM-1 && i_ready)). This path is combinational from i_ready.
- i_clear has priority over every other event. The next state is IDLE and cnt=0; shift_reg is don't-care. No word is accepted in that cycle.
- NUM_SYM==1 is legal: every accepted output transfer can also accept a new word.

## Timing
- Reset values: state IDLE, cnt 0, shift_reg 0, o_valid 0, o_busy 0, o_data 0. o_ready is 1 after reset deassertion.
- Latency: a word accepted at edge k shows symbol 0 on o_data in the cycle after edge k.
- Throughput: 1 symbol/cycle while i_ready=1. A continuous stream of words has no idle cycle between the last symbol of one word and the first symbol of the next.
- Reset asserted mid-word: the word is lost and outputs go to their reset values immediately (asynchronously).
- i_valid may be held high indefinitely. i_data is sampled only on the edge where i_valid&&o_ready.

## Configuration
- CONV_PISO_LAST_EN defined:
  - Adds output port o_last (1 bit), with o_last = o_valid && cnt==NUM_SYM-1. It marks the final symbol of each word.
  - Reset value 0.
- CONV_PISO_LAST_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package conv_pkg holds:
  - typedef enum logic {PISO_IDLE, PISO_SHIFT} piso_state_e;
  - localparam helper for the counter width (max(1, $clog2(n))), shared with the SIPO.
- One sub-module, conv_sym_cnt: a modulo-NUM_SYM counter with inputs clear, load and inc, and output is_last.
- Elaboration-time assertion: SIZE_IN % SIZE_OUT == 0.

## Test plan
- SIZE_IN=16, SIZE_OUT=2, i_data=16'hB4E1, i_ready=1 held → o_data sequence 2,3,1,0,3,2,0,1 on 8 consecutive cycles, o_valid high throughout. With CONV_PISO_LAST_EN, o_last is high only on the final 1.
- Two words 16'hFFFF then 16'h0000 with i_valid held high and i_ready=1 → 8 symbols of 3 immediately followed by 8 symbols of 0. o_ready pulses exactly on the 8th symbol of the first word, and there are no gaps.
- Random i_ready backpressure while streaming 16'hB4E1 → the same 2,3,1,0,3,2,0,1 order, and o_data is stable in every stalled cycle.
- i_clear asserted at symbol 3, together with i_valid=1 and i_data=16'h1234 → no load happens and o_valid=0 in the next cycle. A later i_valid then loads 16'h1234 normally, emitting 0,1,0,2,0,3,1,0.
- i_rst_n pulsed low mid-word → o_valid, o_busy and o_data are 0 during reset, and o_ready=1 after release.
- SIZE_IN=2, SIZE_OUT=2, words 2'b10, 2'b01 back-to-back → o_data 2,1 on consecutive cycles, and o_ready stays high while i_ready=1.
